fp_op_sequencer: RTL and testbench
==================================

// Module: fp_op_sequencer
// PURPOSE
//  Sequences multi-cycle FPALU ops (add/sub, mul, div, sqrt) inside the uniciclo RISC-V core.
//  Freezes the PC while the FPALU computes, then issues the register writeback.
//  Steers the writeback to the FP or integer register bank.
//  Sits between Control_UNI (decoded op class) and the PC register / register-bank write enables.
// PARAMETERS
//  LAT_ADD   3   cycles from start to valid FPALU result for fadd/fsub (>=2)
//  LAT_MUL   4   same, fmul (>=2)
//  LAT_DIV   12  same, fdiv (>=2)
//  LAT_SQRT  16  same, fsqrt (>=2)
//  CNT_W     5   latency counter width; must hold max(LAT_*)-2
// PORTS
//  iCLK          in   1   core clock
//  iRST_N        in   1   asynchronous reset, active-low
//  iStart        in   1   current instruction is a multi-cycle FP op
//  iOpClass      in   3   1=add/sub 2=mul 3=div 4=sqrt; 0,5-7 illegal
//  iRd           in   5   destination register of the instruction
//  iIntDest      in   1   1: result goes to integer bank, 0: FP bank
//  iFPResult     in   32  FPALU result bus
//  iAbort        in   1   synchronous kill of in-flight op
//  iClrStats     in   1   synchronous clear of stall counter
//  oPCWrite      out  1   PC load enable; 0 holds PC
//  oFPStart      out  1   one-cycle start pulse to FPALU
//  oBusy         out  1   state != IDLE
//  oFPRegWrite   out  1   FP bank write enable
//  oRegWrite     out  1   integer bank write enable
//  oWrRd         out  5   writeback register index
//  oWrData       out  32  writeback data
//  oDone         out  1   one-cycle pulse on writeback
//  oIllegal      out  1   one-cycle pulse on illegal op class
//  oStallCycles  out  32  count of cycles with oPCWrite=0
// BEHAVIOUR
//  States: IDLE, RUN, WB. Registered: state, cnt, latched rd/intdest, oStallCycles.
//  All other outputs are combinational from state plus inputs.
//  Reset (iRST_N=0, async): state=IDLE, cnt=0, rd=0, intdest=0, oStallCycles=0.
//  Reset outputs: oPCWrite=1, all other outputs 0.
//  IDLE, iStart=1, class 1-4: oPCWrite=0, oFPStart=1; latch iRd/iIntDest; cnt<=LAT(class)-2; ->RUN.
//  IDLE, iStart=1, class 0/5-7: oIllegal=1, oPCWrite=1, no FPALU start, stay IDLE.
//  IDLE, iStart=0: oPCWrite=1, stay IDLE.
//  RUN: oPCWrite=0. If cnt==0 ->WB, else cnt<=cnt-1. RUN lasts LAT-1 cycles.
//  WB (LAT cycles after start cycle): oPCWrite=1, oDone=1, oWrRd=latched rd, oWrData=iFPResult.
//  WB writes: oFPRegWrite=~intdest, oRegWrite=intdest. Next state IDLE.
//  Instruction occupancy is LAT+1 cycles.
//  iStart is sampled only in IDLE; it is ignored in RUN/WB because the stalled instruction is still presented.
//  FP rd=0 is written (f0 is a real register). Int rd=0 still asserts oRegWrite; Registers discards x0.
//  iAbort in RUN or WB: no write, oDone=0, oPCWrite=1 this cycle, ->IDLE. iAbort in IDLE suppresses iStart.
//  iAbort has priority over WB writeback.
//  oStallCycles += 1 each cycle oPCWrite=0; saturates at 32'hFFFFFFFF.
//  iClrStats forces 0 and wins over a simultaneous increment.
//  Reset mid-operation: in-flight op discarded, no writeback, counter cleared.
// TESTING
//  1. Reset, then fadd (class1, rd=5, intdest=0, result 32'h40400000): PCWrite low 3 cycles.
//     WB in 4th cycle with FPRegWrite=1, WrRd=5, WrData=40400000; oStallCycles=3.
//  2. fsqrt (class4): 16 stall cycles, WB on cycle 17.
//     iStart held high during WB -> no second start, IDLE next cycle.
//  3. Int destination (class1, intdest=1, rd=0): oRegWrite=1, oFPRegWrite=0 in WB.
//  4. iOpClass=6 in IDLE: oIllegal pulse, oPCWrite stays 1, oFPStart=0, state IDLE.
//  5. fdiv, iAbort on 5th RUN cycle: no write enables, oPCWrite=1 that cycle, IDLE next.
//     Then iRST_N low mid-fmul: outputs to reset values asynchronously, counter 0.
//  6. Preload oStallCycles to FFFFFFFE via stalls, run fmul: saturates at FFFFFFFF.
//     iClrStats during stall -> 0.

Source files
------------

// File: rtl/fp_op_sequencer_if.sv
// ============================================================================
//  Module      : fp_op_sequencer_if
//  Description : Bundle between the decode stage and the FP op sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_op_sequencer_if;
    logic        iStart;
    logic [2:0]  iOpClass;
    logic [4:0]  iRd;
    logic        iIntDest;
    logic [31:0] iFPResult;
    logic        iAbort;
    logic        iClrStats;

    logic        oPCWrite;
    logic        oFPStart;
    logic        oBusy;
    logic        oFPRegWrite;
    logic        oRegWrite;
    logic [4:0]  oWrRd;
    logic [31:0] oWrData;
    logic        oDone;
    logic        oIllegal;
    logic [31:0] oStallCycles;

    modport master (
        output iStart, iOpClass, iRd, iIntDest, iFPResult, iAbort, iClrStats,
        input  oPCWrite, oFPStart, oBusy, oFPRegWrite, oRegWrite,
               oWrRd, oWrData, oDone, oIllegal, oStallCycles
    );

    modport slave (
        input  iStart, iOpClass, iRd, iIntDest, iFPResult, iAbort, iClrStats,
        output oPCWrite, oFPStart, oBusy, oFPRegWrite, oRegWrite,
               oWrRd, oWrData, oDone, oIllegal, oStallCycles
    );
endinterface

`default_nettype wire

// File: rtl/fp_op_sequencer.sv
// ============================================================================
//  Module      : fp_op_sequencer
//  Description : Stalls the PC during multi-cycle FPALU ops and issues the
//                writeback to the FP or integer register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_op_sequencer #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 16,
    parameter int CNT_W    = 5
) (
    input  wire logic          iCLK,
    input  wire logic          iRST_N,
    fp_op_sequencer_if.slave   bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_WB   = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ADD  = CNT_W'(LAT_ADD  - 2);
    localparam logic [CNT_W-1:0] c_CNT_MUL  = CNT_W'(LAT_MUL  - 2);
    localparam logic [CNT_W-1:0] c_CNT_DIV  = CNT_W'(LAT_DIV  - 2);
    localparam logic [CNT_W-1:0] c_CNT_SQRT = CNT_W'(LAT_SQRT - 2);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      c_STALL_MAX = 32'hFFFF_FFFF;

    logic [1:0]       r_state, w_stateNext;
    logic [CNT_W-1:0] r_cnt, w_cntNext;
    logic [4:0]       r_rd, w_rdNext;
    logic             r_intDest, w_intDestNext;
    logic [31:0]      r_stallCycles;

    logic             w_legal;
    logic [CNT_W-1:0] w_cntLoad;
    logic             w_req;
    logic             w_pcWrite;

    // Counter preload is LAT-2 so that RUN spans LAT-1 cycles.
    always_comb begin
        w_legal   = 1'b1;
        w_cntLoad = '0;
        case (bus.iOpClass)
            3'd1:    w_cntLoad = c_CNT_ADD;
            3'd2:    w_cntLoad = c_CNT_MUL;
            3'd3:    w_cntLoad = c_CNT_DIV;
            3'd4:    w_cntLoad = c_CNT_SQRT;
            default: w_legal   = 1'b0;
        endcase
    end

    // Abort in IDLE masks the request entirely, including the illegal pulse.
    assign w_req = iRST_N && bus.iStart && !bus.iAbort;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_intDest <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_rd      <= w_rdNext;
            r_intDest <= w_intDestNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_rdNext      = r_rd;
        w_intDestNext = r_intDest;
        case (r_state)
            c_IDLE: begin
                if (w_req && w_legal) begin
                    w_stateNext   = c_RUN;
                    w_cntNext     = w_cntLoad;
                    w_rdNext      = bus.iRd;
                    w_intDestNext = bus.iIntDest;
                end
            end
            c_RUN: begin
                if (bus.iAbort) begin
                    w_stateNext = c_IDLE;
                end else if (r_cnt == '0) begin
                    w_stateNext = c_WB;
                end else begin
                    w_cntNext = r_cnt - c_CNT_ONE;
                end
            end
            c_WB:    w_stateNext = c_IDLE;
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_comb begin
        w_pcWrite       = 1'b1;
        bus.oFPStart    = 1'b0;
        bus.oBusy       = 1'b0;
        bus.oFPRegWrite = 1'b0;
        bus.oRegWrite   = 1'b0;
        bus.oWrRd       = '0;
        bus.oWrData     = '0;
        bus.oDone       = 1'b0;
        bus.oIllegal    = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_pcWrite    = !(w_req && w_legal);
                bus.oFPStart = w_req && w_legal;
                bus.oIllegal = w_req && !w_legal;
            end
            c_RUN: begin
                bus.oBusy = 1'b1;
                w_pcWrite = bus.iAbort;
            end
            c_WB: begin
                bus.oBusy = 1'b1;
                if (!bus.iAbort) begin
                    bus.oDone       = 1'b1;
                    bus.oFPRegWrite = !r_intDest;
                    bus.oRegWrite   = r_intDest;
                    bus.oWrRd       = r_rd;
                    bus.oWrData     = bus.iFPResult;
                end
            end
            default: ;
        endcase
        bus.oPCWrite = w_pcWrite;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_stallCycles <= '0;
        end else if (bus.iClrStats) begin
            r_stallCycles <= '0;
        end else if (!w_pcWrite && (r_stallCycles != c_STALL_MAX)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign bus.oStallCycles = r_stallCycles;

endmodule

`default_nettype wire

// File: tb/tb_fp_op_sequencer.sv
// ============================================================================
//  Module      : tb_fp_op_sequencer
//  Description : Directed plus random stimulus against a transaction-level
//                model of the FP op sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_op_sequencer;

    logic iCLK  = 1'b0;
    logic iRST_N = 1'b0;
    always #5 iCLK = ~iCLK;

    fp_op_sequencer_if bus ();

    fp_op_sequencer #(
        .LAT_ADD (3),
        .LAT_MUL (4),
        .LAT_DIV (12),
        .LAT_SQRT(16),
        .CNT_W   (5)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: an op in flight is tracked by its age in cycles since the start cycle.
    bit          mActive = 1'b0;
    int          mAge    = 0;
    int          mLat    = 0;
    logic [4:0]  mRd     = '0;
    bit          mInt    = 1'b0;
    logic [31:0] mStall  = '0;

    task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int latOf(input logic [2:0] cls);
        case (cls)
            3'd1:    return 3;
            3'd2:    return 4;
            3'd3:    return 12;
            3'd4:    return 16;
            default: return 0;
        endcase
    endfunction

    task automatic modelReset();
        mActive = 1'b0;
        mAge    = 0;
        mStall  = '0;
    endtask

    task automatic evalCycle();
        bit          legal, accept;
        bit          ePC, eStart, eBusy, eFW, eW, eDone, eIll;
        logic [4:0]  eRd;
        logic [31:0] eData;
        ePC = 1'b1; eStart = 1'b0; eBusy = 1'b0; eFW = 1'b0; eW = 1'b0;
        eDone = 1'b0; eIll = 1'b0; eRd = '0; eData = '0; accept = 1'b0;
        if (!mActive) begin
            legal  = latOf(bus.iOpClass) != 0;
            accept = bus.iStart && !bus.iAbort && legal;
            ePC    = !accept;
            eStart = accept;
            eIll   = bus.iStart && !bus.iAbort && !legal;
        end else begin
            eBusy = 1'b1;
            if (!bus.iAbort) begin
                if (mAge < mLat) begin
                    ePC = 1'b0;
                end else begin
                    eDone = 1'b1;
                    eFW   = !mInt;
                    eW    = mInt;
                    eRd   = mRd;
                    eData = bus.iFPResult;
                end
            end
        end
        chkEq("pcwrite",  32'(bus.oPCWrite),    32'(ePC));
        chkEq("fpstart",  32'(bus.oFPStart),    32'(eStart));
        chkEq("busy",     32'(bus.oBusy),       32'(eBusy));
        chkEq("fpregwr",  32'(bus.oFPRegWrite), 32'(eFW));
        chkEq("regwr",    32'(bus.oRegWrite),   32'(eW));
        chkEq("wrrd",     32'(bus.oWrRd),       32'(eRd));
        chkEq("wrdata",   bus.oWrData,          eData);
        chkEq("done",     32'(bus.oDone),       32'(eDone));
        chkEq("illegal",  32'(bus.oIllegal),    32'(eIll));
        chkEq("stallcnt", bus.oStallCycles,     mStall);

        if (mActive) begin
            if (bus.iAbort || mAge >= mLat) mActive = 1'b0;
            else                            mAge++;
        end else if (accept) begin
            mActive = 1'b1;
            mAge    = 1;
            mLat    = latOf(bus.iOpClass);
            mRd     = bus.iRd;
            mInt    = bus.iIntDest;
        end
        if (bus.iClrStats)                  mStall = '0;
        else if (!ePC && mStall != '1)      mStall = mStall + 32'd1;
    endtask

    task automatic drive(input bit st, input logic [2:0] cls, input logic [4:0] rd,
                         input bit intd, input logic [31:0] res, input bit ab, input bit clr);
        bus.iStart    = st;
        bus.iOpClass  = cls;
        bus.iRd       = rd;
        bus.iIntDest  = intd;
        bus.iFPResult = res;
        bus.iAbort    = ab;
        bus.iClrStats = clr;
    endtask

    // Inputs change 1 ns after the edge; outputs are judged on the falling edge.
    task automatic cycle(input bit st, input logic [2:0] cls, input logic [4:0] rd,
                         input bit intd, input logic [31:0] res, input bit ab, input bit clr);
        @(posedge iCLK);
        #1;
        drive(st, cls, rd, intd, res, ab, clr);
        #4;
        evalCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        chkEq("rst_pcwrite", 32'(bus.oPCWrite),  32'd1);
        chkEq("rst_busy",    32'(bus.oBusy),     32'd0);
        chkEq("rst_fpstart", 32'(bus.oFPStart),  32'd0);
        chkEq("rst_stall",   bus.oStallCycles,   32'd0);
        iRST_N = 1'b1;
        modelReset();
        idleCycles(2);

        // fadd to f5: three stall cycles, writeback on the fourth.
        cycle(1'b1, 3'd1, 5'd5, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        chkEq("fadd_stall3", bus.oStallCycles, 32'd3);

        // fsqrt with iStart held through writeback.
        cycle(1'b1, 3'd4, 5'd9, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) cycle(1'b1, 3'd4, 5'd9, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        chkEq("sqrt_idle",   32'(bus.oBusy),   32'd0);
        chkEq("sqrt_stall",  bus.oStallCycles, 32'd19);

        // Integer destination x0.
        cycle(1'b1, 3'd1, 5'd0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

        // Illegal class.
        cycle(1'b1, 3'd6, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0);
        chkEq("ill_pulse", 32'(bus.oIllegal), 32'd1);
        idleCycles(1);

        // fdiv aborted on its fifth RUN cycle.
        cycle(1'b1, 3'd3, 5'd7, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chkEq("abort_pc", 32'(bus.oPCWrite), 32'd1);
        idleCycles(1);

        // Asynchronous reset in the middle of an fmul.
        cycle(1'b1, 3'd2, 5'd4, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
        #2;
        iRST_N = 1'b0;
        #1;
        chkEq("arst_busy",    32'(bus.oBusy),    32'd0);
        chkEq("arst_pcwrite", 32'(bus.oPCWrite), 32'd1);
        chkEq("arst_stall",   bus.oStallCycles,  32'd0);
        modelReset();
        #8;
        iRST_N = 1'b1;
        idleCycles(2);

        // Clear of stall statistics during a stall.
        cycle(1'b1, 3'd2, 5'd2, 1'b0, 32'h4100_0000, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h4100_0000, 1'b0, 1'b1);
        cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h4100_0000, 1'b0, 1'b0);
        chkEq("clr_stall", bus.oStallCycles, 32'd0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 3'd0, 5'd0, 1'b0, 32'h4100_0000, 1'b0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            bit          st, ab, clr, intd;
            logic [2:0]  cls;
            logic [4:0]  rd;
            st   = $urandom_range(0, 2) != 0;
            cls  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
            rd   = 5'($urandom);
            intd = 1'($urandom);
            ab   = $urandom_range(0, 29) == 0;
            clr  = $urandom_range(0, 63) == 0;
            cycle(st, cls, rd, intd, $urandom, ab, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
